eight_output_pulse_decoder: RTL and testbench

- Sequential inverse of the 8-input priority encoder: accepts a valid flag plus a 3-bit code, and drives the matching one-hot line for a fixed pulse width.
- Pulses are separated by a programmable gap. One pending code is buffered; priority rules resolve codes that arrive while busy.
- Sits downstream of the priority encoder. It converts encoded requests back into timed per-line strobes for the eight consumers.

---
 rtl/eight_pd_pkg.sv | 17 +
 rtl/pd_hold_timer.sv | 26 ++
 rtl/eight_output_pulse_decoder.sv | 141 ++++++++++++++
 tb/tb_eight_output_pulse_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/eight_pd_pkg.sv
// Shared definitions for the eight-output pulse decoder: state encoding,
// code/line sizing and the code-to-one-hot decode.
package eight_pd_pkg;

    localparam int CODE_W = 3;
    localparam int LINES  = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    function automatic logic [LINES-1:0] onehot8(input logic [CODE_W-1:0] code);
        onehot8       = '0;
        onehot8[code] = 1'b1;
    endfunction

endpackage

// File: rtl/pd_hold_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module pd_hold_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/eight_output_pulse_decoder.sv
// Turns valid+code requests into fixed-width one-hot strobes separated by a
// gap, with a single priority-resolved pending slot for codes arriving while busy.
module eight_output_pulse_decoder
    import eight_pd_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        in_code,
    output logic [7:0]        out,
    output logic              busy,
    output logic              pend_valid,
    output logic              drop,
    output logic [CNT_W-1:0]  pulse_count
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]        state, state_n;
    logic [7:0]        out_n;
    logic              pend_valid_n, drop_n;
    logic [2:0]        pend_code, pend_code_n;
    logic [CNT_W-1:0]  count_n;
    logic              load;
    logic [TW-1:0]     load_val;
    logic              done;
    logic              finish_gap;
    logic              capture;

    pd_hold_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_comb begin
        state_n      = state;
        out_n        = out;
        pend_valid_n = pend_valid;
        pend_code_n  = pend_code;
        drop_n       = 1'b0;
        count_n      = pulse_count;
        load         = 1'b0;
        load_val     = HOLD_LD;
        finish_gap   = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n = HOLD;
                    out_n   = onehot8(in_code);
                    load    = 1'b1;
                end
            end
            HOLD: begin
                if (done) begin
                    count_n = pulse_count + CNT_W'(1);
                    if (GAP_CYCLES > 0) begin
                        state_n  = GAP;
                        out_n    = '0;
                        load     = 1'b1;
                        load_val = GAP_LD;
                    end else begin
                        finish_gap = 1'b1;
                    end
                end
            end
            GAP: begin
                if (done) finish_gap = 1'b1;
            end
            default: begin
                state_n = IDLE;
                out_n   = '0;
            end
        endcase

        // On the final gap cycle the pending slot drains first; an incoming
        // code then refills the slot unconditionally instead of competing.
        if (finish_gap) begin
            if (pend_valid) begin
                state_n      = HOLD;
                out_n        = onehot8(pend_code);
                load         = 1'b1;
                load_val     = HOLD_LD;
                pend_valid_n = in_valid;
                if (in_valid) pend_code_n = in_code;
            end else if (in_valid) begin
                state_n  = HOLD;
                out_n    = onehot8(in_code);
                load     = 1'b1;
                load_val = HOLD_LD;
            end else begin
                state_n = IDLE;
                out_n   = '0;
            end
        end

        capture = (state == HOLD || state == GAP) && !finish_gap;
        if (capture && in_valid) begin
            if (!pend_valid) begin
                pend_valid_n = 1'b1;
                pend_code_n  = in_code;
            end else if (in_code > pend_code) begin
                pend_code_n = in_code;
                drop_n      = 1'b1;
            end else if (in_code < pend_code) begin
                drop_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out         <= '0;
            busy        <= 1'b0;
            pend_valid  <= 1'b0;
            pend_code   <= '0;
            drop        <= 1'b0;
            pulse_count <= '0;
        end else begin
            state       <= state_n;
            out         <= out_n;
            busy        <= (state_n == HOLD) || (state_n == GAP);
            pend_valid  <= pend_valid_n;
            pend_code   <= pend_code_n;
            drop        <= drop_n;
            pulse_count <= count_n;
        end
    end

endmodule

// File: tb/tb_eight_output_pulse_decoder.sv
// Directed bench: a HOLD=4/GAP=1 instance for the main scenarios and a
// HOLD=4/GAP=0/CNT_W=2 instance for back-to-back pulses and counter wrap.
module tb_eight_output_pulse_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = '0;
    logic [7:0] out;
    logic       busy, pend_valid, drop;
    logic [7:0] pulse_count;

    logic       z_valid = 1'b0;
    logic [2:0] z_code = '0;
    logic [7:0] z_out;
    logic       z_busy, z_pend, z_drop;
    logic [1:0] z_count;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [7:0]  out_seen, z_out_seen;
    logic        drop_seen, z_drop_seen;

    always #5 clk = ~clk;

    eight_output_pulse_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
        .out(out), .busy(busy), .pend_valid(pend_valid), .drop(drop),
        .pulse_count(pulse_count)
    );

    eight_output_pulse_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(2)) dut_z (
        .clk(clk), .rst(rst), .in_valid(z_valid), .in_code(z_code),
        .out(z_out), .busy(z_busy), .pend_valid(z_pend), .drop(z_drop),
        .pulse_count(z_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; values sampled afterwards belong to the next cycle.
    task automatic step();
        @(posedge clk);
        #1;
        out_seen    |= out;
        z_out_seen  |= z_out;
        drop_seen   |= drop;
        z_drop_seen |= z_drop;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; z_valid = 1'b0;
        step();
        rst = 1'b0;
        out_seen = '0; z_out_seen = '0; drop_seen = 1'b0; z_drop_seen = 1'b0;
    endtask

    initial begin
        out_seen = '0; z_out_seen = '0; drop_seen = 1'b0; z_drop_seen = 1'b0;

        // reset state
        do_reset();
        check("rst_out", 32'(out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_pend", 32'(pend_valid), 32'h0);
        check("rst_drop", 32'(drop), 32'h0);
        check("rst_count", 32'(pulse_count), 32'h0);

        // 1: single pulse
        in_valid = 1'b1; in_code = 3'd5;
        step(); in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("t1_out_hold", 32'(out), 32'h20);
            check("t1_busy_hold", 32'(busy), 32'h1);
            step();
        end
        check("t1_out_gap", 32'(out), 32'h0);
        check("t1_busy_gap", 32'(busy), 32'h1);
        step();
        check("t1_busy_idle", 32'(busy), 32'h0);
        check("t1_count", 32'(pulse_count), 32'h1);

        // 2: queued code
        do_reset();
        in_valid = 1'b1; in_code = 3'd2;
        step(); in_valid = 1'b0;
        check("t2_out_c1", 32'(out), 32'h04);
        step();
        in_valid = 1'b1; in_code = 3'd6;
        step(); in_valid = 1'b0;
        check("t2_pend_c3", 32'(pend_valid), 32'h1);
        check("t2_out_c3", 32'(out), 32'h04);
        step(); step();
        check("t2_out_c5", 32'(out), 32'h0);
        check("t2_pend_c5", 32'(pend_valid), 32'h1);
        step();
        for (int c = 6; c <= 9; c++) begin
            check("t2_out_second", 32'(out), 32'h40);
            check("t2_pend_clear", 32'(pend_valid), 32'h0);
            step();
        end
        check("t2_out_c10", 32'(out), 32'h0);
        step();
        check("t2_busy_idle", 32'(busy), 32'h0);
        check("t2_count", 32'(pulse_count), 32'h2);
        check("t2_no_drop", 32'(drop_seen), 32'h0);

        // 3: replace and discard
        do_reset();
        in_valid = 1'b1; in_code = 3'd2; step();
        in_code = 3'd3; step();
        check("t3_pend_c2", 32'(pend_valid), 32'h1);
        check("t3_drop_c2", 32'(drop), 32'h0);
        in_code = 3'd7; step();
        check("t3_drop_replace", 32'(drop), 32'h1);
        in_code = 3'd1; step(); in_valid = 1'b0;
        check("t3_drop_discard", 32'(drop), 32'h1);
        check("t3_out_c4", 32'(out), 32'h04);
        step();
        check("t3_drop_c5", 32'(drop), 32'h0);
        check("t3_pend_c5", 32'(pend_valid), 32'h1);
        step();
        for (int c = 6; c <= 9; c++) begin
            check("t3_out_seven", 32'(out), 32'h80);
            step();
        end
        step();
        check("t3_count", 32'(pulse_count), 32'h2);
        check("t3_lines_seen", 32'(out_seen), 32'h84);

        // 4: reset mid-pulse
        do_reset();
        in_valid = 1'b1; in_code = 3'd4; step();
        in_code = 3'd1; step();
        in_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
        check("t4_out", 32'(out), 32'h0);
        check("t4_busy", 32'(busy), 32'h0);
        check("t4_pend", 32'(pend_valid), 32'h0);
        check("t4_count", 32'(pulse_count), 32'h0);
        out_seen = '0;
        for (int c = 0; c < 8; c++) step();
        check("t4_no_pulse", 32'(out_seen), 32'h0);
        check("t4_busy_later", 32'(busy), 32'h0);

        // 5: direct load on the last gap cycle
        do_reset();
        in_valid = 1'b1; in_code = 3'd3; step(); in_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("t5_busy_c5", 32'(busy), 32'h1);
        check("t5_out_c5", 32'(out), 32'h0);
        check("t5_pend_c5", 32'(pend_valid), 32'h0);
        in_valid = 1'b1; in_code = 3'd0; step(); in_valid = 1'b0;
        for (int c = 6; c <= 9; c++) begin
            check("t5_out_direct", 32'(out), 32'h01);
            step();
        end
        check("t5_out_c10", 32'(out), 32'h0);
        step();
        check("t5_idle", 32'(busy), 32'h0);
        check("t5_count", 32'(pulse_count), 32'h2);

        // 6: zero gap and counter wrap
        do_reset();
        z_valid = 1'b1; z_code = 3'd4; step();
        check("t6_out_c1", 32'(z_out), 32'h10);
        step(); z_valid = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            check("t6_out_cont", 32'(z_out), 32'h10);
            step();
        end
        check("t6_out_c9", 32'(z_out), 32'h0);
        check("t6_busy_c9", 32'(z_busy), 32'h0);
        check("t6_count2", 32'(z_count), 32'h2);
        check("t6_no_drop", 32'(z_drop_seen), 32'h0);
        for (int p = 0; p < 4; p++) begin
            z_valid = 1'b1; z_code = 3'(p); step(); z_valid = 1'b0;
            for (int c = 0; c < 4; c++) step();
            if (p == 1) check("t6_wrap0", 32'(z_count), 32'h0);
        end
        check("t6_wrap_final", 32'(z_count), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
